// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci job scheduler: the FSM state
// encoding and the default datapath widths.
package fibo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NREQ   = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

endpackage : fibo_pkg

// File: rtl/fibo_core.sv
// Fibonacci engine: holds the pair (a, b), reloads it to (0, 1) on load
// and advances it one term per step. Sums wrap modulo 2^DATA_W.
module fibo_core
  import fibo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] a
);

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;

  // Engine pair: reset/load to (0,1), otherwise advance on step.
  // NOTE: sequential state uses non-blocking assignments so r_a and r_b
  // both update from their pre-edge values, giving a true pair swap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a <= '0;
      r_b <= DATA_W'(1);
    end else if (load) begin
      r_a <= '0;
      r_b <= DATA_W'(1);
    end else if (step) begin
      r_a <= r_b;
      r_b <= r_a + r_b;
    end
  end

  assign a = r_a;

endmodule : fibo_core

// File: rtl/fibo_sched.sv
// Round-robin scheduler in front of a single Fibonacci engine. Requesters
// post a step count N; one job runs at a time and returns F(N) mod
// 2^DATA_W together with the requester index.
module fibo_sched
  import fibo_pkg::*;
#(
  parameter  int NREQ   = DEF_NREQ,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*CNT_W-1:0] req_steps,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [DATA_W-1:0]     resp_data,
  input  logic                  resp_ready,
  output logic                  busy
);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_ptr;

  logic              w_grant_any;
  logic [ID_W-1:0]   w_grant_idx;
  int                w_cand;
  logic [CNT_W-1:0]  w_steps;
  logic [NREQ-1:0]   w_ready;
  logic              w_accept;
  logic              w_load;
  logic              w_step;
  logic [DATA_W-1:0] w_a;

  // Round-robin pick: first valid requester after the last granted index.
  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = int'(r_ptr) + k;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      if (!w_grant_any && req_valid[ID_W'(w_cand)]) begin
        w_grant_any = 1'b1;
        w_grant_idx = ID_W'(w_cand);
      end
    end
  end

  // Step count of the granted requester and the one-hot accept strobe;
  // reset forces the strobe low so every output is quiet during reset.
  always_comb begin
    w_steps  = '0;
    w_ready  = '0;
    w_accept = rst && (r_state == IDLE) && w_grant_any;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == ID_W'(i)) w_steps = req_steps[i*CNT_W +: CNT_W];
    end
    if (w_accept) w_ready[w_grant_idx] = 1'b1;
  end

  // FSM next state and engine controls.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load = 1'b1;
          w_next = (w_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(1)) w_next = DONE;
      end
      DONE: begin
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Job bookkeeping: remaining steps, owner id and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_id  <= '0;
      r_ptr <= ID_W'(NREQ - 1);
    end else if (w_accept) begin
      r_cnt <= w_steps;
      r_id  <= w_grant_idx;
      r_ptr <= w_grant_idx;
    end else if (w_step) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  fibo_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .step (w_step),
    .a    (w_a)
  );

  assign req_ready  = w_ready;
  assign resp_valid = (r_state == DONE);
  assign resp_data  = resp_valid ? w_a  : '0;
  assign resp_id    = resp_valid ? r_id : '0;
  assign busy       = (r_state != IDLE);

endmodule : fibo_sched

// File: doc/fibo_sched.md
FIBO_SCHED -- requirements
Module: fibo_sched

Interface
REQ-001 The block SHALL use one clock `clk` and reset `rst`; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be: NREQ, default 2, number of requesters; DATA_W, default 8, Fibonacci word width; CNT_W, default 8, step-count width.
REQ-003 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  clock
- rst  in  1  async active-low reset
- req_valid  in  NREQ  per-requester job request
- req_steps  in  NREQ*CNT_W  step count N; requester i in slice [i*CNT_W +: CNT_W]
- req_ready  out  NREQ  one-hot accept strobe
- resp_valid  out  1  result available
- resp_id  out  $clog2(NREQ), min 1  requester index of result
- resp_data  out  DATA_W  F(N) mod 2^DATA_W
- resp_ready  in  1  result consumed
- busy  out  1  high in any state other than IDLE

Function
REQ-004 The block SHALL own one Fibonacci engine with state (a,b); a step SHALL perform (a,b) <= (b, a+b), with the addition truncated to DATA_W.
REQ-005 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-006 In IDLE with any req_valid high, the block SHALL grant exactly one requester in round-robin order, starting after the last granted index; the pointer reset value SHALL be NREQ-1, so requester 0 wins first.
REQ-007 req_ready[g] SHALL be combinational, high only in IDLE for the granted g; transfer occurs when req_valid[g] and req_ready[g] are both high.
REQ-008 On acceptance, the block SHALL load (a,b) <= (0,1), cnt <= req_steps[g] and id <= g, then enter RUN if N != 0, or DONE if N == 0.
REQ-009 In RUN, the engine SHALL step once per cycle and decrement cnt; after the step where cnt goes 1 -> 0, the block SHALL enter DONE.
REQ-010 Latency: for a job accepted at edge t, resp_valid SHALL first be high in the cycle after edge t+N, i.e. N+1 cycles after acceptance.
REQ-011 In DONE, resp_valid SHALL be 1, resp_data SHALL be a, and resp_id SHALL be the stored id; these SHALL stay stable until resp_ready is high.
REQ-012 DONE with resp_ready high SHALL return the FSM to IDLE; no new grant SHALL occur in that cycle, so there is at least one bubble between jobs.
REQ-013 req_valid and req_steps changes outside IDLE SHALL be ignored; requests are not queued.
REQ-014 resp_ready SHALL be ignored outside DONE.
REQ-015 Outside DONE, resp_valid SHALL be 0 and resp_data and resp_id SHALL be 0.
REQ-016 N = 2^CNT_W - 1 SHALL run to completion with no count wrap.

Reset
REQ-017 Asserting rst (low) at any time SHALL asynchronously force: FSM to IDLE, (a,b) = (0,1), cnt = 0, id = 0, and the round-robin pointer to NREQ-1.
REQ-018 During reset, all outputs SHALL be 0.
REQ-019 An in-flight job SHALL be discarded with no response.
REQ-020 After deassertion, the first grant SHALL follow REQ-006.

Structure
REQ-021 A shared package fibo_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default DATA_W and CNT_W constants.
REQ-022 The engine SHALL be a sub-module fibo_core with inputs clk, rst, load and step and output a.
REQ-023 Arbitration, the counter and the FSM SHALL live in fibo_sched.

Verification
REQ-024 Single job: requester 0, N=10, resp_ready tied high -> resp_valid high 11 cycles after acceptance with resp_data=55 and resp_id=0, for one cycle only.
REQ-025 Wrap arithmetic: N=14 -> resp_data=121, since 377 mod 256 = 121.
REQ-026 N=0 -> resp_data=0 one cycle after acceptance.
REQ-027 N=1 -> resp_data=1.
REQ-028 Round robin: both requesters hold valid continuously with N=12 and N=13 -> responses alternate in id order 0,1,0,1 with data 144,233,144,233; req_ready is never high for both in the same cycle.
REQ-029 Backpressure: N=5 with resp_ready low for 7 cycles -> resp_valid, resp_data=5 and resp_id held stable; busy stays high; no grant occurs until the handshake completes.
REQ-030 Reset mid-RUN: rst low while N=200 is running -> all outputs 0 immediately with no response; after release, a new N=10 job returns 55.
